control_flow_unit: RTL

CONTROL_FLOW_UNIT -- requirements
Module: control_flow_unit

---
 rtl/control_flow_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/control_flow_unit.sv
// Branch/jump resolution and fetch-redirect control with a fixed-depth flush window.
// Define CFU_BRANCH_CMP_EN to enable the compare branches (bne, blt, bex).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | accepting instructions at decode, stall low
// WAIT_OPND | jr accepted before rd_val was current; waiting for rd_ready
// FLUSH     | transfer issued; squashing FLUSH_DEPTH younger slots
module control_flow_unit #(
  parameter int PC_W        = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [4:0]      opcode,
  input  logic [26:0]     target,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic [31:0]     rd_val,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rstatus,
  input  logic            rd_ready,
  output logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            link_we,
  output logic [31:0]     link_data,
  output logic [15:0]     taken_count
);

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_FLUSH     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_q;
  logic [PC_W-1:0]   redirect_pc_q;
  logic              link_we_q;
  logic [31:0]       link_data_q;
  logic [15:0]       taken_q;

  logic              is_j, is_jal, is_jr, is_bne, is_blt, is_bex;
  logic [31:0]       tgt_abs32;
  logic [31:0]       imm32;
  logic [PC_W-1:0]   tgt_br;
  logic [31:0]       link_ext;
  logic              xfer_take;
  logic [PC_W-1:0]   xfer_pc;
  logic              accept;
  logic              jr_wait;
  logic              fire;
  logic [PC_W-1:0]   fire_pc;
  logic              link_fire;

  // Decode and target/condition evaluation for the instruction at decode.
  always_comb begin
    is_j      = (opcode == OP_J);
    is_jal    = (opcode == OP_JAL);
    is_jr     = (opcode == OP_JR);
`ifdef CFU_BRANCH_CMP_EN
    is_bne    = (opcode == OP_BNE);
    is_blt    = (opcode == OP_BLT);
    is_bex    = (opcode == OP_BEX);
`else
    is_bne    = 1'b0;
    is_blt    = 1'b0;
    is_bex    = 1'b0;
`endif
    tgt_abs32 = {5'b0, target};
    imm32     = {{15{target[16]}}, target[16:0]};
    tgt_br    = pc_plus1 + imm32[PC_W-1:0];
    link_ext  = '0;
    link_ext[PC_W-1:0] = pc_plus1;

    xfer_take = 1'b0;
    xfer_pc   = tgt_abs32[PC_W-1:0];
    if (is_j || is_jal) begin
      xfer_take = 1'b1;
    end else if (is_jr) begin
      xfer_take = rd_ready;
      xfer_pc   = rd_val[PC_W-1:0];
    end else if (is_bne) begin
      xfer_take = (rd_val != rs_val);
      xfer_pc   = tgt_br;
    end else if (is_blt) begin
      xfer_take = ($signed(rd_val) < $signed(rs_val));
      xfer_pc   = tgt_br;
    end else if (is_bex) begin
      xfer_take = (rstatus != 32'd0);
    end
  end

`ifndef CFU_BRANCH_CMP_EN
  logic unused_cmp_operands;
  assign unused_cmp_operands = ^{rs_val, rstatus};
`endif

  always_comb begin
    accept    = valid_in && (state_q == ST_IDLE);
    jr_wait   = accept && is_jr && !rd_ready;
    link_fire = accept && is_jal;
    fire      = 1'b0;
    fire_pc   = xfer_pc;
    if (state_q == ST_IDLE) begin
      fire = accept && xfer_take;
    end else if (state_q == ST_WAIT_OPND) begin
      fire    = rd_ready;
      fire_pc = rd_val[PC_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LAST;
        end else if (jr_wait) begin
          state_d = ST_WAIT_OPND;
        end
      end
      ST_WAIT_OPND: begin
        if (fire) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LAST;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall       = (state_q != ST_IDLE);
    flush       = (state_q == ST_FLUSH);
    redirect    = redirect_q;
    redirect_pc = redirect_pc_q;
    link_we     = link_we_q;
    link_data   = link_data_q;
    taken_count = taken_q;
  end

  // Strobes last one cycle; their data registers hold between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_we_q     <= 1'b0;
      link_data_q   <= '0;
      taken_q       <= '0;
    end else begin
      redirect_q <= fire;
      link_we_q  <= link_fire;
      if (fire) begin
        redirect_pc_q <= fire_pc;
        taken_q       <= taken_q + 16'd1;
      end
      if (link_fire) begin
        link_data_q <= link_ext;
      end
    end
  end

endmodule
